// File: rtl/rgb2ycbcr_pipe_pkg.sv
// Shared definitions for the RGB -> YCbCr pipeline: conversion modes,
// output channels, the Q8 coefficient table, offsets and rounding constants.
package ycbcr_pkg;

  typedef enum logic [1:0] {
    MODE_601_FULL = 2'd0,
    MODE_601_LIM  = 2'd1,
    MODE_709_FULL = 2'd2,
    MODE_709_LIM  = 2'd3
  } ycbcr_mode_e;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } ycbcr_ch_e;

  typedef logic signed [8:0] coef_t;

  // Q8 coefficients indexed [mode][output channel][R,G,B].
  localparam coef_t YCBCR_COEF [4][3][3] = '{
    '{ '{ 9'sd77,   9'sd150,  9'sd29  },
       '{-9'sd43,  -9'sd85,   9'sd128 },
       '{ 9'sd128, -9'sd107, -9'sd21  } },
    '{ '{ 9'sd66,   9'sd129,  9'sd25  },
       '{-9'sd38,  -9'sd74,   9'sd112 },
       '{ 9'sd112, -9'sd94,  -9'sd18  } },
    '{ '{ 9'sd54,   9'sd183,  9'sd19  },
       '{-9'sd29,  -9'sd99,   9'sd128 },
       '{ 9'sd128, -9'sd116, -9'sd12  } },
    '{ '{ 9'sd47,   9'sd157,  9'sd16  },
       '{-9'sd26,  -9'sd87,   9'sd112 },
       '{ 9'sd112, -9'sd102, -9'sd10  } }
  };

  // Offsets at 8-bit scale; they are shifted up by (DW-8) for wider pixels.
  localparam int Y_OFF_LIM_BASE = 16;
  localparam int C_OFF_BASE     = 128;

  // Round-to-nearest constant and the Q8 shift applied after the sum.
  localparam int YCBCR_ROUND = 128;
  localparam int YCBCR_SHIFT = 8;

  function automatic coef_t ycbcr_coef(ycbcr_mode_e m, ycbcr_ch_e ch, logic [1:0] comp);
    return YCBCR_COEF[m][ch][comp];
  endfunction

  function automatic logic mode_is_limited(ycbcr_mode_e m);
    return (m == MODE_601_LIM) || (m == MODE_709_LIM);
  endfunction

endpackage

// File: rtl/rgb2ycbcr_pipe_if.sv
// Pixel-stream bundle around rgb2ycbcr_pipe: input syncs/RGB with ready,
// output syncs/YCbCr with downstream ready. The master drives pixels in and
// accepts results; the slave is the converter side.
interface rgb2ycbcr_pipe_if #(parameter int DW = 8);
  import ycbcr_pkg::*;

  ycbcr_mode_e   mode;
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic          per_ready;
  logic [DW-1:0] per_img_red;
  logic [DW-1:0] per_img_green;
  logic [DW-1:0] per_img_blue;
  logic          post_frame_vsync;
  logic          post_frame_href;
  logic          post_frame_clken;
  logic          post_ready;
  logic [DW-1:0] post_img_Y;
  logic [DW-1:0] post_img_Cb;
  logic [DW-1:0] post_img_Cr;

  modport master (
    output mode, per_frame_vsync, per_frame_href, per_frame_clken,
           per_img_red, per_img_green, per_img_blue, post_ready,
    input  per_ready, post_frame_vsync, post_frame_href, post_frame_clken,
           post_img_Y, post_img_Cb, post_img_Cr
  );

  modport slave (
    input  mode, per_frame_vsync, per_frame_href, per_frame_clken,
           per_img_red, per_img_green, per_img_blue, post_ready,
    output per_ready, post_frame_vsync, post_frame_href, post_frame_clken,
           post_img_Y, post_img_Cb, post_img_Cr
  );
endinterface

// File: rtl/rgb2ycbcr_pipe_mac3.sv
// ycbcr_mac3: one output channel of the converter. Four stages:
// multiply (unsigned magnitudes + sign), signed sum, round/shift/offset, clamp.
// Every stage holds its contents while adv_i is low.
module ycbcr_mac3
  import ycbcr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv_i,
  input  logic [DW-1:0]   r_i,
  input  logic [DW-1:0]   g_i,
  input  logic [DW-1:0]   b_i,
  input  coef_t           kr_i,
  input  coef_t           kg_i,
  input  coef_t           kb_i,
  input  logic [DW-1:0]   offset_i,
  output logic [DW-1:0]   res_o
);

  localparam int PW = DW + 8;
  localparam int SW = DW + 10;
  localparam logic signed [SW-1:0] ROUND_S = SW'(YCBCR_ROUND);
  localparam logic signed [SW-1:0] MAX_S   = SW'({DW{1'b1}});

  logic [7:0]              mag_r, mag_g, mag_b;
  logic [PW-1:0]           pr_d, pg_d, pb_d;
  logic [PW-1:0]           pr_q, pg_q, pb_q;
  logic                    nr_q, ng_q, nb_q;
  logic [DW-1:0]           off1_q, off2_q;
  logic signed [SW-1:0]    sum_d, sum_q;
  logic signed [SW-1:0]    rnd, res3_d, res3_q;
  logic [DW-1:0]           res4_d, res4_q;

  function automatic logic signed [SW-1:0] signed_term(logic [PW-1:0] p, logic neg);
    logic signed [SW-1:0] t;
    t = signed'({2'b00, p});
    return neg ? -t : t;
  endfunction

  // Stage 1 combinational: coefficient magnitudes times components.
  always_comb begin
    mag_r = kr_i[8] ? 8'(-kr_i) : kr_i[7:0];
    mag_g = kg_i[8] ? 8'(-kg_i) : kg_i[7:0];
    mag_b = kb_i[8] ? 8'(-kb_i) : kb_i[7:0];
    pr_d  = PW'(r_i) * PW'(mag_r);
    pg_d  = PW'(g_i) * PW'(mag_g);
    pb_d  = PW'(b_i) * PW'(mag_b);
  end

  // Stages 2-4 combinational: signed sum, Q8 round with offset, clamp.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res4_d = '0;
    sum_d  = signed_term(pr_q, nr_q) + signed_term(pg_q, ng_q) + signed_term(pb_q, nb_q);
    rnd    = (sum_q + ROUND_S) >>> YCBCR_SHIFT;
    res3_d = rnd + signed'(SW'(off2_q));
    if (res3_q > MAX_S) begin
      res4_d = {DW{1'b1}};
    end else if (res3_q >= 0) begin
      res4_d = res3_q[DW-1:0];
    end
  end

  // Pipeline registers; advance together, freeze together.
  // NOTE: state is written with non-blocking assignments so all stages sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      nr_q   <= 1'b0;
      ng_q   <= 1'b0;
      nb_q   <= 1'b0;
      off1_q <= '0;
      off2_q <= '0;
      sum_q  <= '0;
      res3_q <= '0;
      res4_q <= '0;
    end else if (adv_i) begin
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      nr_q   <= kr_i[8];
      ng_q   <= kg_i[8];
      nb_q   <= kb_i[8];
      off1_q <= offset_i;
      off2_q <= off1_q;
      sum_q  <= sum_d;
      res3_q <= res3_d;
      res4_q <= res4_d;
    end
  end

  assign res_o = res4_q;

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 4-stage RGB -> YCbCr converter with ready/valid flow
// control. The conversion mode is latched at each frame start (vsync rise)
// and applies to the whole frame.
// Optional build macro YCBCR_422_EN: 4:2:2 output, Cb and Cr of each even
// pixel interleaved on post_img_Cb, post_img_Cr driven 0. Undefined -> 4:4:4.
module rgb2ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  output logic          per_ready,
  input  logic [DW-1:0] per_img_red,
  input  logic [DW-1:0] per_img_green,
  input  logic [DW-1:0] per_img_blue,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  input  logic          post_ready,
  output logic [DW-1:0] post_img_Y,
  output logic [DW-1:0] post_img_Cb,
  output logic [DW-1:0] post_img_Cr
);

  localparam logic [DW-1:0] Y_OFF_LIM = DW'(Y_OFF_LIM_BASE) << (DW - 8);
  localparam logic [DW-1:0] C_OFF     = DW'(C_OFF_BASE) << (DW - 8);

  logic          adv;
  logic          vs_prev_q;
  logic          vs_rise;
  ycbcr_mode_e   mode_q, mode_d;
  logic [DW-1:0] y_off;
  logic [3:0]    vs_pipe_q, hr_pipe_q, ck_pipe_q;
  logic [DW-1:0] y_res, cb_res, cr_res;
  logic [DW-1:0] cb_sel, cr_sel;

  // Whole pipeline moves when the output slot is empty or being taken.
  always_comb begin
    adv     = !ck_pipe_q[3] || post_ready;
    vs_rise = per_frame_vsync && !vs_prev_q;
    mode_d  = vs_rise ? ycbcr_mode_e'(mode) : mode_q;
    y_off   = mode_is_limited(mode_d) ? Y_OFF_LIM : '0;
  end

  assign per_ready = adv;

  // Frame-start detection and mode latch, evaluated on advancing cycles only.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      mode_q    <= MODE_601_FULL;
    end else if (adv) begin
      vs_prev_q <= per_frame_vsync;
      mode_q    <= mode_d;
    end
  end

  // Sync/valid shift chain running in lock-step with the data stages.
  // NOTE: the control chain is reset so a mid-frame reset leaves no valid beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_pipe_q <= '0;
      hr_pipe_q <= '0;
      ck_pipe_q <= '0;
    end else if (adv) begin
      vs_pipe_q <= {vs_pipe_q[2:0], per_frame_vsync};
      hr_pipe_q <= {hr_pipe_q[2:0], per_frame_href};
      ck_pipe_q <= {ck_pipe_q[2:0], per_frame_clken};
    end
  end

  ycbcr_mac3 #(.DW(DW)) u_mac_y (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (adv),
    .r_i      (per_img_red),
    .g_i      (per_img_green),
    .b_i      (per_img_blue),
    .kr_i     (ycbcr_coef(mode_d, CH_Y, 2'd0)),
    .kg_i     (ycbcr_coef(mode_d, CH_Y, 2'd1)),
    .kb_i     (ycbcr_coef(mode_d, CH_Y, 2'd2)),
    .offset_i (y_off),
    .res_o    (y_res)
  );

  ycbcr_mac3 #(.DW(DW)) u_mac_cb (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (adv),
    .r_i      (per_img_red),
    .g_i      (per_img_green),
    .b_i      (per_img_blue),
    .kr_i     (ycbcr_coef(mode_d, CH_CB, 2'd0)),
    .kg_i     (ycbcr_coef(mode_d, CH_CB, 2'd1)),
    .kb_i     (ycbcr_coef(mode_d, CH_CB, 2'd2)),
    .offset_i (C_OFF),
    .res_o    (cb_res)
  );

  ycbcr_mac3 #(.DW(DW)) u_mac_cr (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (adv),
    .r_i      (per_img_red),
    .g_i      (per_img_green),
    .b_i      (per_img_blue),
    .kr_i     (ycbcr_coef(mode_d, CH_CR, 2'd0)),
    .kg_i     (ycbcr_coef(mode_d, CH_CR, 2'd1)),
    .kb_i     (ycbcr_coef(mode_d, CH_CR, 2'd2)),
    .offset_i (C_OFF),
    .res_o    (cr_res)
  );

`ifdef YCBCR_422_EN
  logic       hr_prev_q;
  logic       hr_rise;
  logic       phase_q;
  logic       phase_cur;
  logic [3:0] ph_pipe_q;
  logic [DW-1:0] cr_hold_q;

  // Phase of the beat at the input: a new line always starts even.
  always_comb begin
    hr_rise   = per_frame_href && !hr_prev_q;
    phase_cur = hr_rise ? 1'b0 : phase_q;
  end

  // Pixel phase per accepted beat, its pipeline copy, and the even pixel's Cr.
  always_ff @(posedge clk) begin
    if (rst) begin
      hr_prev_q <= 1'b0;
      phase_q   <= 1'b0;
      ph_pipe_q <= '0;
      cr_hold_q <= '0;
    end else if (adv) begin
      hr_prev_q <= per_frame_href;
      if (per_frame_clken) begin
        phase_q <= !phase_cur;
      end else if (hr_rise) begin
        phase_q <= 1'b0;
      end
      ph_pipe_q <= {ph_pipe_q[2:0], phase_cur};
      if (ck_pipe_q[3] && !ph_pipe_q[3]) begin
        cr_hold_q <= cr_res;
      end
    end
  end

  // Even beats carry Cb, odd beats carry the preceding even pixel's Cr.
  always_comb begin
    cb_sel = cb_res;
    cr_sel = '0;
    if (ph_pipe_q[3]) begin
      cb_sel = cr_hold_q;
    end
  end
`else
  // 4:4:4 output straight from the channel MACs.
  always_comb begin
    cb_sel = cb_res;
    cr_sel = cr_res;
  end
`endif

  assign post_frame_vsync = vs_pipe_q[3];
  assign post_frame_href  = hr_pipe_q[3];
  assign post_frame_clken = ck_pipe_q[3];
  assign post_img_Y       = hr_pipe_q[3] ? y_res  : '0;
  assign post_img_Cb      = hr_pipe_q[3] ? cb_sel : '0;
  assign post_img_Cr      = hr_pipe_q[3] ? cr_sel : '0;

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Scoreboard bench for rgb2ycbcr_pipe: the driver computes expected YCbCr
// from the conversion formulas and queues it; an independent monitor pops
// and compares whenever an output beat is taken. A DW=10 instance covers
// the wide-pixel offsets. Handles builds with YCBCR_422_EN too.
module tb_rgb2ycbcr_pipe;
  import ycbcr_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb2ycbcr_pipe_if #(.DW(DW)) bus ();

  rgb2ycbcr_pipe #(.DW(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (bus.mode),
    .per_frame_vsync  (bus.per_frame_vsync),
    .per_frame_href   (bus.per_frame_href),
    .per_frame_clken  (bus.per_frame_clken),
    .per_ready        (bus.per_ready),
    .per_img_red      (bus.per_img_red),
    .per_img_green    (bus.per_img_green),
    .per_img_blue     (bus.per_img_blue),
    .post_frame_vsync (bus.post_frame_vsync),
    .post_frame_href  (bus.post_frame_href),
    .post_frame_clken (bus.post_frame_clken),
    .post_ready       (bus.post_ready),
    .post_img_Y       (bus.post_img_Y),
    .post_img_Cb      (bus.post_img_Cb),
    .post_img_Cr      (bus.post_img_Cr)
  );

  // Wide-pixel instance, driven directly.
  logic [1:0] w_mode;
  logic       w_vs, w_hr, w_ck, w_per_ready, w_pvs, w_phr, w_pck;
  logic [9:0] w_r, w_g, w_b, w_y, w_cb, w_cr;

  rgb2ycbcr_pipe #(.DW(10)) dut10 (
    .clk              (clk),
    .rst              (rst),
    .mode             (w_mode),
    .per_frame_vsync  (w_vs),
    .per_frame_href   (w_hr),
    .per_frame_clken  (w_ck),
    .per_ready        (w_per_ready),
    .per_img_red      (w_r),
    .per_img_green    (w_g),
    .per_img_blue     (w_b),
    .post_frame_vsync (w_pvs),
    .post_frame_href  (w_phr),
    .post_frame_clken (w_pck),
    .post_ready       (1'b1),
    .post_img_Y       (w_y),
    .post_img_Cb      (w_cb),
    .post_img_Cr      (w_cr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: coefficient table [mode][Y,Cb,Cr][R,G,B].
  int K [4][3][3] = '{
    '{ '{77, 150, 29},  '{-43, -85, 128},  '{128, -107, -21} },
    '{ '{66, 129, 25},  '{-38, -74, 112},  '{112, -94, -18}  },
    '{ '{54, 183, 19},  '{-29, -99, 128},  '{128, -116, -12} },
    '{ '{47, 157, 16},  '{-26, -87, 112},  '{112, -102, -10} }
  };

  function automatic int ref_conv(int md, int ch, int r, int g, int b, int dw);
    int sum, v, off;
    sum = K[md][ch][0] * r + K[md][ch][1] * g + K[md][ch][2] * b;
    if (ch == 0) off = (md == 1 || md == 3) ? (16 << (dw - 8)) : 0;
    else         off = 128 << (dw - 8);
    v = ((sum + 128) >>> 8) + off;
    if (v < 0) v = 0;
    if (v > (1 << dw) - 1) v = (1 << dw) - 1;
    return v;
  endfunction

  typedef struct { int y; int cb; int cr; int vs; int hr; } exp_t;
  exp_t sb[$];

  // Model of the frame-level rules.
  int m_mode, m_vs_prev, m_hr_prev, m_phase, m_even_cr;

  task automatic model_reset();
    m_mode = 0; m_vs_prev = 0; m_hr_prev = 0; m_phase = 0; m_even_cr = 0;
  endtask

  // One input cycle at the falling edge; acc tells whether the next rising edge takes it.
  task automatic drive_cycle(input bit ck, input bit vs, input bit hr,
                             input int r, input int g, input int b, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.per_frame_clken = ck;
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = hr;
    bus.per_img_red     = r[DW-1:0];
    bus.per_img_green   = g[DW-1:0];
    bus.per_img_blue    = b[DW-1:0];
    acc = ck && bus.per_ready;
    if (bus.per_ready) begin
      if (vs && !m_vs_prev) m_mode = int'(bus.mode);
      m_vs_prev = vs;
      if (hr && !m_hr_prev) m_phase = 0;
      m_hr_prev = hr;
      if (acc) begin
        e.vs = vs;
        e.hr = hr;
        e.y  = ref_conv(m_mode, 0, r, g, b, DW);
        e.cb = ref_conv(m_mode, 1, r, g, b, DW);
        e.cr = ref_conv(m_mode, 2, r, g, b, DW);
`ifdef YCBCR_422_EN
        if (m_phase == 0) m_even_cr = e.cr;
        else              e.cb = m_even_cr;
        e.cr = 0;
        m_phase ^= 1;
`endif
        if (!hr) begin e.y = 0; e.cb = 0; e.cr = 0; end
        sb.push_back(e);
      end
    end
  endtask

  task automatic send(input bit vs, input bit hr, input int r, input int g, input int b);
    bit acc;
    int n;
    n = 0;
    do begin
      drive_cycle(1'b1, vs, hr, r, g, b, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) fail_now("send_accept");
  endtask

  task automatic idle(input int n, input bit hr);
    bit acc;
    repeat (n) drive_cycle(1'b0, 1'b0, hr, 0, 0, 0, acc);
  endtask

  task automatic vsync_pulse(input int md);
    bit acc;
    bus.mode = ycbcr_mode_e'(md[1:0]);
    drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, acc);
    drive_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, acc);
  endtask

  // Downstream ready: scripted low stretch, random backpressure, or always ready.
  bit bp_en    = 1'b0;
  int hold_low = 0;
  initial begin
    bus.post_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_low > 0) begin
        bus.post_ready = 1'b0;
        hold_low--;
      end else if (bp_en) begin
        bus.post_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.post_ready = 1'b1;
      end
    end
  end

  // Monitor: compares each consumed output beat and checks stall behaviour.
  int   stall_cycles = 0;
  bit   stall_seen   = 1'b0;
  int   snap;
  always @(negedge clk) begin : monitor
    exp_t e;
    int   cur;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      cur = {bus.post_img_Y, bus.post_img_Cb, bus.post_img_Cr,
             bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken};
      if (stall_seen) check("hold_outputs", cur, snap);
      stall_seen = 1'b0;
      if (bus.post_frame_clken) begin
        if (bus.post_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_Y",     int'(bus.post_img_Y),  e.y);
            check("out_Cb",    int'(bus.post_img_Cb), e.cb);
            check("out_Cr",    int'(bus.post_img_Cr), e.cr);
            check("out_vsync", int'(bus.post_frame_vsync), e.vs);
            check("out_href",  int'(bus.post_frame_href),  e.hr);
          end
        end else begin
          check("per_ready_stall", int'(bus.per_ready), 0);
          stall_cycles++;
          snap       = cur;
          stall_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    int s0;
    int n;
    rst = 1'b1;
    bus.mode = MODE_601_FULL;
    bus.per_frame_vsync = 0; bus.per_frame_href = 0; bus.per_frame_clken = 0;
    bus.per_img_red = 0; bus.per_img_green = 0; bus.per_img_blue = 0;
    w_mode = 0; w_vs = 0; w_hr = 0; w_ck = 0; w_r = 0; w_g = 0; w_b = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_per_ready", int'(bus.per_ready), 1);
    check("rst_post_clken", int'(bus.post_frame_clken), 0);
    check("rst_post_sync", int'({bus.post_frame_vsync, bus.post_frame_href}), 0);
    check("rst_post_img", int'({bus.post_img_Y, bus.post_img_Cb, bus.post_img_Cr}), 0);
    check("rst_w_per_ready", int'(w_per_ready), 1);

    // Wide pixels: mode 3, black -> limited offsets scaled to 10 bits.
    w_mode = 2'd3; w_vs = 1'b1;
    @(negedge clk);
    w_vs = 1'b0; w_hr = 1'b1; w_ck = 1'b1;
    @(negedge clk);
    w_ck = 1'b0;
    repeat (2) @(negedge clk);
    check("w_lat3_clken", int'(w_pck), 0);
    @(negedge clk);
    check("w_lat4_clken", int'(w_pck), 1);
    check("w_Y", int'(w_y), 64);
    check("w_Cb", int'(w_cb), 512);
`ifdef YCBCR_422_EN
    check("w_Cr", int'(w_cr), 0);
`else
    check("w_Cr", int'(w_cr), 512);
`endif
    w_hr = 1'b0;

    // White in mode 0 with a 4-cycle latency check, then red, then href-low beat.
    vsync_pulse(0);
    send(0, 1, 255, 255, 255);
    idle(3, 1'b1);
    check("lat3_clken", int'(bus.post_frame_clken), 0);
    idle(1, 1'b1);
    check("lat4_clken", int'(bus.post_frame_clken), 1);
    check("white_Y", int'(bus.post_img_Y), 255);
    idle(2, 1'b0);
    send(0, 1, 255, 0, 0);
    send(0, 1, 0, 0, 255);
    idle(1, 1'b0);
    send(0, 0, 255, 255, 255);
    idle(6, 1'b0);

    // Eight beats with downstream held off for three cycles mid-stream.
    s0 = stall_cycles;
    for (int i = 0; i < 8; i++) begin
      send(0, 1, 30 * i, 255 - 20 * i, 17 * i);
      if (i == 5) hold_low = 3;
    end
    idle(10, 1'b0);
    check("stall_cycles", stall_cycles - s0, 3);

    // Mode change mid-frame takes effect only at the next frame.
    vsync_pulse(0);
    send(0, 1, 255, 0, 0);
    bus.mode = MODE_709_FULL;
    send(0, 1, 255, 0, 0);
    send(0, 1, 255, 255, 255);
    idle(1, 1'b0);
    vsync_pulse(2);
    send(0, 1, 255, 255, 255);
    send(0, 1, 255, 0, 0);
    idle(6, 1'b0);

    // Randomized frames with random backpressure.
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      vsync_pulse(int'($urandom_range(0, 3)));
      for (int l = 0; l < 3; l++) begin
        for (int p = 0; p < 8; p++)
          send(0, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)));
        idle(1, 1'b0);
      end
    end
    bp_en = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin idle(1, 1'b0); n++; end
    check("drain_random", sb.size(), 0);

    // Mid-frame reset: in-flight beats are discarded, mode falls back to 0.
    vsync_pulse(2);
    send(0, 1, 200, 100, 50);
    send(0, 1, 10, 20, 30);
    send(0, 1, 90, 90, 90);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    model_reset();
    bus.per_frame_clken = 1'b0;
    bus.per_frame_href  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_post_clken", int'(bus.post_frame_clken), 0);
    check("mrst_per_ready", int'(bus.per_ready), 1);
    bus.mode = MODE_709_LIM;
    send(0, 1, 255, 0, 0);
    send(0, 1, 0, 0, 255);
    n = 0;
    while (sb.size() != 0 && n < 50) begin idle(1, 1'b0); n++; end
    idle(6, 1'b0);
    check("drain_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb2ycbcr_pipe.md
RGB2YCBCR_PIPE -- requirements
Module: rgb2ycbcr_pipe

Interface
REQ-001 SHALL have parameter DW, default 8, meaning component bit width (legal range 8..12).
REQ-002 SHALL have ports `clk  in  1`, the single clock; all logic is on its rising edge.
REQ-003 SHALL have `rst  in  1`, a reset that is synchronous and active-high.
REQ-004 SHALL have `mode  in  2`: 0=BT.601 full, 1=BT.601 limited, 2=BT.709 full, 3=BT.709 limited.
REQ-005 SHALL have `per_frame_vsync`, `per_frame_href`, `per_frame_clken  in  1`: input sync signals and pixel-valid.
REQ-006 SHALL have `per_ready  out  1`: the input beat is accepted when clken=1 and per_ready=1.
REQ-007 SHALL have `per_img_red`, `per_img_green`, `per_img_blue  in  DW`: RGB pixel.
REQ-008 SHALL have `post_frame_vsync`, `post_frame_href`, `post_frame_clken  out  1`: delayed syncs and output-valid.
REQ-009 SHALL have `post_ready  in  1`: downstream accept.
REQ-010 SHALL have `post_img_Y`, `post_img_Cb`, `post_img_Cr  out  DW`: YCbCr pixel.

Function
REQ-011 SHALL advance the pipeline on adv = !post_frame_clken || post_ready, with per_ready = adv.
REQ-012 SHALL be a 4-stage pipeline: multiply, sum, round/shift/offset, clamp; latency is 4 advancing cycles.
REQ-013 SHALL carry vsync, href and clken through all stages with the data and hold them when adv=0; bubbles propagate.
REQ-014 SHALL use these Q8 coefficients (R,G,B) for mode 0: Y 77,150,29; Cb -43,-85,128; Cr 128,-107,-21.
REQ-015 SHALL use for mode 1: Y 66,129,25; Cb -38,-74,112; Cr 112,-94,-18.
REQ-016 SHALL use for mode 2: Y 54,183,19; Cb -29,-99,128; Cr 128,-116,-12.
REQ-017 SHALL use for mode 3: Y 47,157,16; Cb -26,-87,112; Cr 112,-102,-10.
REQ-018 SHALL compute out = ((sum + 128) >>> 8) + offset, where >>> is an arithmetic right shift (floor).
REQ-019 SHALL use offsets of Y 0 (full) or 16<<(DW-8) (limited), and Cb/Cr 128<<(DW-8).
REQ-020 SHALL size products DW+8 unsigned and sums as DW+10 signed; no intermediate overflow is permitted.
REQ-021 SHALL clamp results to [0, 2^DW-1].
REQ-022 SHALL latch mode into a mode register on the rising edge of per_frame_vsync among accepted/advancing cycles, so a mid-frame mode change has no effect until the next frame.
REQ-023 SHALL apply the mode register to the whole frame.
REQ-024 SHALL force post_img_* to 0 while post_frame_href=0.
REQ-025 SHALL hold all outputs stable while post_frame_clken=1 and post_ready=0.
REQ-026 SHALL neither drop nor duplicate beats.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, clear all pipeline stages, post_* outputs to 0, the mode register to 0 and the 4:2:2 phase to even.
REQ-028 SHALL drive per_ready=1 in the cycle after reset.
REQ-029 SHALL discard in-flight data on a mid-frame reset with no partial output; the mode register stays 0 until the next vsync rise.

Configuration
REQ-030 SHALL provide macro YCBCR_422_EN, absent by default; when it is undefined the block produces 4:4:4 output as above.
REQ-031 SHALL, when YCBCR_422_EN is defined, keep a pixel phase toggled per accepted beat and reset to even on each rising href at the input.
REQ-032 SHALL, when YCBCR_422_EN is defined, set post_img_Cb = Cb of the even pixel on even beats and Cr of that same even pixel on odd beats, with post_img_Cr driven 0.
REQ-033 SHALL keep latency unchanged when YCBCR_422_EN is defined.

Structure
REQ-034 SHALL place the mode enum, the 4x3x3 signed coefficient table, offset localparams and rounding constant in package ycbcr_pkg.
REQ-035 SHALL implement one sub-module ycbcr_mac3: a 3-term signed MAC with round/offset/clamp, honoring adv, instantiated three times (Y, Cb, Cr).

Verification
REQ-036 SHALL cover: DW=8, mode 0, RGB (255,255,255), post_ready=1 -> after 4 cycles Y=255, Cb=128, Cr=128, post_frame_clken=1.
REQ-037 SHALL cover: DW=8, mode 0, RGB (255,0,0) -> Y=77, Cb=85, Cr=255 (saturated from 256).
REQ-038 SHALL cover: DW=8, mode 3, RGB (0,0,0) -> Y=16, Cb=128, Cr=128; with DW=10 -> Y=64, Cb=512, Cr=512.
REQ-039 SHALL cover: a stream of 8 beats with post_ready low for 3 cycles mid-stream -> per_ready low for those cycles, outputs frozen, all 8 results in order with none lost.
REQ-040 SHALL cover: mode switched 0->2 mid-frame -> remaining frame uses mode 0 coefficients, next frame after vsync rise uses mode 2 (white -> Y=255).
REQ-041 SHALL cover: with YCBCR_422_EN, a pixel pair (255,0,0),(0,0,255) in mode 0 -> post_img_Cb sequence 85, then 255, with post_img_Cr=0.
